// File: rtl/genius_pkg.sv
// Shared types and colour constants for the Genius quadrant renderer:
// quadrant encoding, flash-sequencer states and full-intensity base colours.
package genius_pkg;

    typedef enum logic [1:0] {
        Q_GREEN  = 2'd0,
        Q_RED    = 2'd1,
        Q_YELLOW = 2'd2,
        Q_BLUE   = 2'd3
    } quad_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        LIT  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [23:0] COL_GREEN  = 24'h00FF00;
    localparam logic [23:0] COL_RED    = 24'hFF0000;
    localparam logic [23:0] COL_YELLOW = 24'hFFFF00;
    localparam logic [23:0] COL_BLUE   = 24'h0000FF;

    function automatic logic [23:0] base_colour(input quad_t q);
        logic [23:0] c;
        case (q)
            Q_GREEN:  c = COL_GREEN;
            Q_RED:    c = COL_RED;
            Q_YELLOW: c = COL_YELLOW;
            default:  c = COL_BLUE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/genius_flash_seq.sv
// Command handshake and lit/gap sequencer; all state changes after ARM
// happen on frame_start so a lit period always covers whole frames.
module genius_flash_seq
    import genius_pkg::*;
#(
    parameter int GAP_FRAMES = 4
) (
    input  logic       VGA_CLK,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_quad,
    input  logic [7:0] cmd_frames,
    output logic       busy,
    output logic       lit_on,
    output logic [1:0] lit_quad,
    output state_t     state
);

    // Handshake: a command transfers on a clock edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is high only in IDLE, so a source that
    // offers while busy simply holds its command until the block returns.

    state_t     state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] frames_q, frames_nxt;
    logic [1:0] quad_q, quad_nxt;

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            frames_q <= 8'd0;
            quad_q   <= 2'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            frames_q <= frames_nxt;
            quad_q   <= quad_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        frames_nxt = frames_q;
        quad_nxt   = quad_q;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt  = ARM;
                    frames_nxt = cmd_frames;
                    quad_nxt   = cmd_quad;
                end
            end
            ARM: begin
                if (frame_start) begin
                    state_nxt = LIT;
                    cnt_nxt   = (frames_q == 8'd0) ? 8'd1 : frames_q;
                end
            end
            LIT: begin
                if (frame_start) begin
                    if (cnt == 8'd1) begin
                        cnt_nxt   = 8'(GAP_FRAMES);
                        state_nxt = (GAP_FRAMES == 0) ? IDLE : GAP;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            GAP: begin
                if (frame_start) begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign lit_on    = (state == LIT);
    assign lit_quad  = quad_q;

endmodule

// File: rtl/genius_quad_renderer.sv
// Colour stage for the four Genius quadrants, one register of latency.
// Optional GENIUS_BORDER_EN draws a 4-pixel black cross between quadrants.
module genius_quad_renderer
    import genius_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int GAP_FRAMES = 4,
    parameter int DIM_SHIFT  = 1
) (
    input  logic       VGA_CLK,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_active,
    input  logic       frame_start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_quad,
    input  logic [7:0] cmd_frames,
    output logic       busy,
    output logic [1:0] lit_quad,
    output logic       lit_on,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       active_d
);

    localparam logic [9:0] H_HALF = 10'(H_ACTIVE / 2);
    localparam logic [9:0] V_HALF = 10'(V_ACTIVE / 2);

    state_t      seq_state;
    quad_t       quad;
    logic [23:0] base;
    logic [23:0] dim;
    logic        quad_lit;
    logic        on_border;

    genius_flash_seq #(
        .GAP_FRAMES(GAP_FRAMES)
    ) u_seq (
        .VGA_CLK    (VGA_CLK),
        .reset      (reset),
        .frame_start(frame_start),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_quad   (cmd_quad),
        .cmd_frames (cmd_frames),
        .busy       (busy),
        .lit_on     (lit_on),
        .lit_quad   (lit_quad),
        .state      (seq_state)
    );

    always_comb begin
        quad     = quad_t'({pix_y >= V_HALF, pix_x >= H_HALF});
        base     = base_colour(quad);
        dim      = {base[23:16] >> DIM_SHIFT, base[15:8] >> DIM_SHIFT, base[7:0] >> DIM_SHIFT};
        quad_lit = (seq_state == LIT) && (lit_quad == quad);
    end

`ifdef GENIUS_BORDER_EN
    localparam logic [9:0] H_B_LO = 10'(H_ACTIVE / 2 - 2);
    localparam logic [9:0] H_B_HI = 10'(H_ACTIVE / 2 + 1);
    localparam logic [9:0] V_B_LO = 10'(V_ACTIVE / 2 - 2);
    localparam logic [9:0] V_B_HI = 10'(V_ACTIVE / 2 + 1);
    assign on_border = ((pix_x >= H_B_LO) && (pix_x <= H_B_HI)) ||
                       ((pix_y >= V_B_LO) && (pix_y <= V_B_HI));
`else
    assign on_border = 1'b0;
`endif

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            {VGA_R, VGA_G, VGA_B} <= 24'd0;
            active_d              <= 1'b0;
        end else begin
            active_d <= pix_active;
            if (!pix_active || on_border)
                {VGA_R, VGA_G, VGA_B} <= 24'd0;
            else if (quad_lit)
                {VGA_R, VGA_G, VGA_B} <= base;
            else
                {VGA_R, VGA_G, VGA_B} <= dim;
        end
    end

endmodule

// File: tb/tb_genius_quad_renderer.sv
// Directed bench for genius_quad_renderer: reset state, colour map, frame
// sequencing, busy handshake, mid-command reset and the quadrant boundaries.
module tb_genius_quad_renderer;

    localparam int FRAME_GAP = 1000;

    logic       VGA_CLK;
    logic       reset;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_active;
    logic       frame_start;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_quad;
    logic [7:0] cmd_frames;
    logic       busy;
    logic [1:0] lit_quad;
    logic       lit_on;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       active_d;

    int checks;
    int errors;
    logic [23:0] exp_q[$];
    logic        border_on;

    genius_quad_renderer dut (
        .VGA_CLK    (VGA_CLK),
        .reset      (reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_active (pix_active),
        .frame_start(frame_start),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_quad   (cmd_quad),
        .cmd_frames (cmd_frames),
        .busy       (busy),
        .lit_quad   (lit_quad),
        .lit_on     (lit_on),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .active_d   (active_d)
    );

    // clock / reset
    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    // drive one pixel, expect its colour on the next cycle via the scoreboard
    task automatic pix_check(input string tag, input int x, input int y,
                             input logic act, input logic [23:0] exp);
        logic [23:0] e;
        pix_x      = 10'(x);
        pix_y      = 10'(y);
        pix_active = act;
        exp_q.push_back(exp);
        step();
        e = exp_q.pop_front();
        check(tag, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, e});
        check({tag, "_act"}, {31'd0, active_d}, {31'd0, act});
    endtask

    // idle until the next frame boundary, then pulse frame_start for one cycle
    task automatic do_frame();
        repeat (FRAME_GAP - 1) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] q, input logic [7:0] n);
        cmd_valid  = 1'b1;
        cmd_quad   = q;
        cmd_frames = n;
        step();
        cmd_valid  = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
`ifdef GENIUS_BORDER_EN
        border_on   = 1'b1;
`else
        border_on   = 1'b0;
`endif
        reset       = 1'b1;
        pix_x       = 10'd0;
        pix_y       = 10'd0;
        pix_active  = 1'b1;
        frame_start = 1'b0;
        cmd_valid   = 1'b0;
        cmd_quad    = 2'd0;
        cmd_frames  = 8'd0;
        repeat (3) step();
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lit_on", {31'd0, lit_on}, 32'd0);
        check("rst_lit_quad", {30'd0, lit_quad}, 32'd0);
        check("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check("rst_active_d", {31'd0, active_d}, 32'd0);
        reset = 1'b0;

        // idle colour map: everything dim
        pix_check("idle_q0", 10, 10, 1'b1, 24'h007F00);
        pix_check("idle_q3", 639, 479, 1'b1, 24'h00007F);
        pix_check("idle_q2", 100, 300, 1'b1, 24'h7F7F00);
        pix_check("blank", 200, 300, 1'b0, 24'h000000);

        // q1 for 3 frames, 4 gap frames
        send_cmd(2'd1, 8'd3);
        check("arm_ready", {31'd0, cmd_ready}, 32'd0);
        check("arm_busy", {31'd0, busy}, 32'd1);
        check("arm_lit_on", {31'd0, lit_on}, 32'd0);
        pix_check("arm_q1", 400, 100, 1'b1, 24'h7F0000);
        for (int f = 1; f <= 8; f++) begin
            do_frame();
            check($sformatf("f%0d_lit_on", f), {31'd0, lit_on}, {31'd0, (f <= 3)});
            check($sformatf("f%0d_busy", f), {31'd0, busy}, {31'd0, (f < 8)});
            pix_check($sformatf("f%0d_q1", f), 400, 100, 1'b1, (f <= 3) ? 24'hFF0000 : 24'h7F0000);
        end
        check("f8_ready", {31'd0, cmd_ready}, 32'd1);
        check("f1_lit_quad", {30'd0, lit_quad}, 32'd1);

        // frames = 0 lights for one frame; a held second command waits for IDLE
        send_cmd(2'd2, 8'd0);
        cmd_valid  = 1'b1;
        cmd_quad   = 2'd3;
        cmd_frames = 8'd1;
        step();
        check("hold_ready", {31'd0, cmd_ready}, 32'd0);
        do_frame();
        check("z_lit_on", {31'd0, lit_on}, 32'd1);
        check("z_lit_quad", {30'd0, lit_quad}, 32'd2);
        pix_check("z_q2", 100, 300, 1'b1, 24'hFFFF00);
        pix_check("z_q0", 10, 10, 1'b1, 24'h007F00);
        do_frame();
        check("z_off", {31'd0, lit_on}, 32'd0);
        for (int f = 3; f <= 5; f++) begin
            do_frame();
            check($sformatf("z%0d_busy", f), {31'd0, busy}, 32'd1);
        end
        do_frame();
        check("z6_busy", {31'd0, busy}, 32'd0);
        check("z6_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        check("held_accept", {31'd0, busy}, 32'd1);
        do_frame();
        check("held_lit_quad", {30'd0, lit_quad}, 32'd3);
        pix_check("held_q3", 600, 400, 1'b1, 24'h0000FF);

        // reset while lit aborts the command
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_lit_on", {31'd0, lit_on}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        pix_check("abort_q1", 400, 100, 1'b1, 24'h7F0000);
        pix_check("abort_q3", 600, 400, 1'b1, 24'h00007F);
        do_frame();
        check("abort_stay", {31'd0, lit_on}, 32'd0);

        // quadrant splits and separator, with q0 lit
        send_cmd(2'd0, 8'd2);
        do_frame();
        pix_check("b_319_50", 319, 50, 1'b1, border_on ? 24'h0 : 24'h00FF00);
        pix_check("b_320_50", 320, 50, 1'b1, border_on ? 24'h0 : 24'h7F0000);
        pix_check("b_319_240", 319, 240, 1'b1, border_on ? 24'h0 : 24'h7F7F00);
        pix_check("b_320_240", 320, 240, 1'b1, border_on ? 24'h0 : 24'h00007F);
        pix_check("b_317_50", 317, 50, 1'b1, 24'h00FF00);
        pix_check("b_322_237", 322, 237, 1'b1, 24'h7F0000);
        pix_check("b_off", 319, 50, 1'b0, 24'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
